// File: rtl/mem_bus_sequencer_pkg.sv
// Shared types and constants for the memory bus sequencer.
// Bus FSM states, bus owner encoding and the wait-counter width.
package mem_bus_sequencer_pkg;

    localparam int WAIT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        STROBE,
        ACK
    } bus_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } bus_owner_t;

endpackage

// File: rtl/mem_bus_sequencer_arb.sv
// rr_arbiter2: two-way round-robin choice with a pointer flop.
// Ports: req[1:0] in, upd_en/upd_last update the pointer, gnt[1:0] one-hot.
module rr_arbiter2 (
    input  logic       Clock,
    input  logic       nReset,
    input  logic [1:0] req,
    input  logic       upd_en,
    input  logic       upd_last,
    output logic [1:0] gnt
);

    // ptr = 0 favours req[0], ptr = 1 favours req[1]
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (upd_en) begin
            ptr_d = ~upd_last;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_bus_sequencer.sv
// Multiplexed address/data bus sequencer with CPU/DMA round-robin arbitration.
// Ports: Cpu*/Dma* request ports, RData, pad side AdOut/AdOe/AdIn, ALE, nME/nOE/nWE, Busy.
module mem_bus_sequencer
    import mem_bus_sequencer_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             CpuReq,
    input  logic             CpuWrite,
    input  logic [WIDTH-1:0] CpuAddr,
    input  logic [WIDTH-1:0] CpuWData,
    output logic             CpuGnt,
    output logic             CpuAck,
    input  logic             DmaReq,
    input  logic             DmaWrite,
    input  logic [WIDTH-1:0] DmaAddr,
    input  logic [WIDTH-1:0] DmaWData,
    output logic             DmaGnt,
    output logic             DmaAck,
    output logic [WIDTH-1:0] RData,
    output logic [WIDTH-1:0] AdOut,
    output logic             AdOe,
    input  logic [WIDTH-1:0] AdIn,
    output logic             ALE,
    output logic             nME,
    output logic             nOE,
    output logic             nWE,
    output logic             Busy
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

    bus_state_t        state_q, state_d;
    bus_owner_t        owner_q, owner_d;
    logic              write_q, write_d;
    logic [WIDTH-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;

    logic              ale_q, ale_d;
    logic              nme_q, nme_d;
    logic              noe_q, noe_d;
    logic              nwe_q, nwe_d;
    logic              adoe_q, adoe_d;
    logic [WIDTH-1:0]  adout_q, adout_d;
    logic              cpu_gnt_q, cpu_gnt_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_gnt_q, dma_gnt_d;
    logic              dma_ack_q, dma_ack_d;
    logic              busy_q, busy_d;

    logic [1:0]        arb_gnt;
    logic              gnt_on;
    logic              ack_on;

    rr_arbiter2 u_arb (
        .Clock    (Clock),
        .nReset   (nReset),
        .req      ({DmaReq, CpuReq}),
        .upd_en   (state_q == ACK),
        .upd_last (owner_q == OWN_DMA),
        .gnt      (arb_gnt)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    state_d = ADDR;
                    if (arb_gnt[1]) begin
                        owner_d = OWN_DMA;
                        write_d = DmaWrite;
                        addr_d  = DmaAddr;
                        wdata_d = DmaWData;
                    end else begin
                        owner_d = OWN_CPU;
                        write_d = CpuWrite;
                        addr_d  = CpuAddr;
                        wdata_d = CpuWData;
                    end
                end
            end
            ADDR: begin
                state_d = STROBE;
                cnt_d   = WAIT_INIT;
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                    if (!write_q) begin
                        rdata_d = AdIn;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pad/handshake outputs are decoded from the next state so they
    // come straight out of flops, aligned with the state they describe.
    always_comb begin
        ale_d   = 1'b0;
        nme_d   = 1'b1;
        noe_d   = 1'b1;
        nwe_d   = 1'b1;
        adoe_d  = 1'b0;
        adout_d = '0;
        gnt_on  = 1'b0;
        ack_on  = 1'b0;
        unique case (state_d)
            IDLE: begin
            end
            ADDR: begin
                ale_d   = 1'b1;
                nme_d   = 1'b0;
                adoe_d  = 1'b1;
                adout_d = addr_d;
                gnt_on  = 1'b1;
            end
            STROBE: begin
                nme_d  = 1'b0;
                gnt_on = 1'b1;
                if (write_d) begin
                    nwe_d   = 1'b0;
                    adoe_d  = 1'b1;
                    adout_d = wdata_d;
                end else begin
                    noe_d = 1'b0;
                end
            end
            ACK: begin
                gnt_on = 1'b1;
                ack_on = 1'b1;
            end
        endcase
        cpu_gnt_d = gnt_on && (owner_d == OWN_CPU);
        dma_gnt_d = gnt_on && (owner_d == OWN_DMA);
        cpu_ack_d = ack_on && (owner_d == OWN_CPU);
        dma_ack_d = ack_on && (owner_d == OWN_DMA);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= IDLE;
            owner_q   <= OWN_CPU;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            ale_q     <= 1'b0;
            nme_q     <= 1'b1;
            noe_q     <= 1'b1;
            nwe_q     <= 1'b1;
            adoe_q    <= 1'b0;
            adout_q   <= '0;
            cpu_gnt_q <= 1'b0;
            cpu_ack_q <= 1'b0;
            dma_gnt_q <= 1'b0;
            dma_ack_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            ale_q     <= ale_d;
            nme_q     <= nme_d;
            noe_q     <= noe_d;
            nwe_q     <= nwe_d;
            adoe_q    <= adoe_d;
            adout_q   <= adout_d;
            cpu_gnt_q <= cpu_gnt_d;
            cpu_ack_q <= cpu_ack_d;
            dma_gnt_q <= dma_gnt_d;
            dma_ack_q <= dma_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign CpuGnt = cpu_gnt_q;
    assign CpuAck = cpu_ack_q;
    assign DmaGnt = dma_gnt_q;
    assign DmaAck = dma_ack_q;
    assign RData  = rdata_q;
    assign AdOut  = adout_q;
    assign AdOe   = adoe_q;
    assign ALE    = ale_q;
    assign nME    = nme_q;
    assign nOE    = noe_q;
    assign nWE    = nwe_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Directed bench for mem_bus_sequencer: WAIT_STATES 1 main instance
// plus WAIT_STATES 3 and 0 instances for latency checks.
module tb_mem_bus_sequencer;

    logic        Clock = 1'b0;
    logic        nReset = 1'b1;
    logic        CpuReq = 0, CpuWrite = 0;
    logic [15:0] CpuAddr = '0, CpuWData = '0;
    logic        DmaReq = 0, DmaWrite = 0;
    logic [15:0] DmaAddr = '0, DmaWData = '0;
    logic [15:0] AdIn = '0;
    logic        CpuGnt, CpuAck, DmaGnt, DmaAck;
    logic [15:0] RData, AdOut;
    logic        AdOe, ALE, nME, nOE, nWE, Busy;

    logic        c3_req = 0, c0_req = 0;
    logic        c3_gnt, c3_ack, c3_dgnt, c3_dack;
    logic        c3_adoe, c3_ale, c3_nme, c3_noe, c3_nwe, c3_busy;
    logic [15:0] c3_rdata, c3_adout;
    logic        c0_gnt, c0_ack, c0_dgnt, c0_dack;
    logic        c0_adoe, c0_ale, c0_nme, c0_noe, c0_nwe, c0_busy;
    logic [15:0] c0_rdata, c0_adout;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    mem_bus_sequencer #(.WIDTH(16), .WAIT_STATES(1)) dut (
        .Clock(Clock), .nReset(nReset),
        .CpuReq(CpuReq), .CpuWrite(CpuWrite),
        .CpuAddr(CpuAddr), .CpuWData(CpuWData),
        .CpuGnt(CpuGnt), .CpuAck(CpuAck),
        .DmaReq(DmaReq), .DmaWrite(DmaWrite),
        .DmaAddr(DmaAddr), .DmaWData(DmaWData),
        .DmaGnt(DmaGnt), .DmaAck(DmaAck),
        .RData(RData), .AdOut(AdOut), .AdOe(AdOe), .AdIn(AdIn),
        .ALE(ALE), .nME(nME), .nOE(nOE), .nWE(nWE), .Busy(Busy)
    );

    mem_bus_sequencer #(.WIDTH(16), .WAIT_STATES(3)) dut3 (
        .Clock(Clock), .nReset(nReset),
        .CpuReq(c3_req), .CpuWrite(1'b0),
        .CpuAddr(CpuAddr), .CpuWData(CpuWData),
        .CpuGnt(c3_gnt), .CpuAck(c3_ack),
        .DmaReq(1'b0), .DmaWrite(1'b0),
        .DmaAddr(16'h0000), .DmaWData(16'h0000),
        .DmaGnt(c3_dgnt), .DmaAck(c3_dack),
        .RData(c3_rdata), .AdOut(c3_adout), .AdOe(c3_adoe), .AdIn(AdIn),
        .ALE(c3_ale), .nME(c3_nme), .nOE(c3_noe), .nWE(c3_nwe), .Busy(c3_busy)
    );

    mem_bus_sequencer #(.WIDTH(16), .WAIT_STATES(0)) dut0 (
        .Clock(Clock), .nReset(nReset),
        .CpuReq(c0_req), .CpuWrite(1'b0),
        .CpuAddr(CpuAddr), .CpuWData(CpuWData),
        .CpuGnt(c0_gnt), .CpuAck(c0_ack),
        .DmaReq(1'b0), .DmaWrite(1'b0),
        .DmaAddr(16'h0000), .DmaWData(16'h0000),
        .DmaGnt(c0_dgnt), .DmaAck(c0_dack),
        .RData(c0_rdata), .AdOut(c0_adout), .AdOe(c0_adoe), .AdIn(AdIn),
        .ALE(c0_ale), .nME(c0_nme), .nOE(c0_noe), .nWE(c0_nwe), .Busy(c0_busy)
    );

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int seq_n, acks, cacks, dacks, ovl, bad;
    int seq [4];
    int lat3, lat0, s3, s0;
    int ale_c [2];
    int ack_c [2];
    int na, nk, busy5;

    initial begin
        #2 nReset = 1'b0;
        #1;
        chk("rst_ale_async", ALE, 0);
        step();
        step();
        chk("rst_ale", ALE, 0);
        chk("rst_nme", nME, 1);
        chk("rst_noe", nOE, 1);
        chk("rst_nwe", nWE, 1);
        chk("rst_adoe", AdOe, 0);
        chk("rst_adout", AdOut, 0);
        chk("rst_rdata", RData, 0);
        chk("rst_gnt", {CpuGnt, DmaGnt}, 0);
        chk("rst_ack", {CpuAck, DmaAck}, 0);
        chk("rst_busy", Busy, 0);
        nReset = 1'b1;
        step();

        // CPU read, WAIT_STATES 1
        CpuReq = 1; CpuWrite = 0; CpuAddr = 16'h0040; AdIn = 16'hBEEF;
        step();
        chk("rd_c1_ale", ALE, 1);
        chk("rd_c1_adout", AdOut, 16'h0040);
        chk("rd_c1_adoe", AdOe, 1);
        chk("rd_c1_nme", nME, 0);
        chk("rd_c1_gnt", {CpuGnt, DmaGnt}, 2'b10);
        chk("rd_c1_busy", Busy, 1);
        step();
        chk("rd_c2_strb", {ALE, nOE, nWE, AdOe}, 4'b0010);
        step();
        chk("rd_c3_strb", {ALE, nOE, nWE, AdOe}, 4'b0010);
        step();
        chk("rd_c4_ack", {CpuAck, DmaAck}, 2'b10);
        chk("rd_c4_gnt", CpuGnt, 1);
        chk("rd_c4_rdata", RData, 16'hBEEF);
        chk("rd_c4_strb", {nME, nOE, nWE, AdOe}, 4'b1110);
        CpuReq = 0; AdIn = 16'h0000;
        step();
        chk("rd_c5_ack", CpuAck, 0);
        chk("rd_c5_busy", Busy, 0);
        chk("rd_c5_rdata_hold", RData, 16'hBEEF);

        // DMA write
        DmaReq = 1; DmaWrite = 1; DmaAddr = 16'h1234; DmaWData = 16'h5A5A;
        step();
        chk("wr_c1_adout", AdOut, 16'h1234);
        chk("wr_c1_gnt", {CpuGnt, DmaGnt}, 2'b01);
        step();
        chk("wr_c2_adout", AdOut, 16'h5A5A);
        chk("wr_c2_strb", {AdOe, nWE, nOE}, 3'b101);
        step();
        chk("wr_c3_strb", {AdOe, nWE, nOE}, 3'b101);
        chk("wr_c3_cpugnt", CpuGnt, 0);
        step();
        chk("wr_c4_ack", {CpuAck, DmaAck}, 2'b01);
        chk("wr_c4_turn", {AdOe, nWE}, 2'b01);
        DmaReq = 0; DmaWrite = 0;
        step();
        chk("wr_c5_ack", DmaAck, 0);
        chk("rdata_not_written", RData, 16'hBEEF);

        // Both requesting: alternate CPU, DMA, CPU, DMA
        CpuReq = 1; DmaReq = 1; CpuAddr = 16'h0100; DmaAddr = 16'h0200;
        seq_n = 0; acks = 0; cacks = 0; dacks = 0; ovl = 0; bad = 0;
        for (int i = 1; i <= 19; i++) begin
            step();
            if (ALE && seq_n < 4) begin
                seq[seq_n] = DmaGnt ? 1 : 0;
                seq_n++;
            end
            if (CpuAck) cacks++;
            if (DmaAck) dacks++;
            if (CpuAck && DmaAck) ovl++;
            if (CpuGnt && DmaGnt) ovl++;
            if (!nOE && !nWE) bad++;
            if (ALE && (!nOE || !nWE)) bad++;
        end
        CpuReq = 0; DmaReq = 0;
        step();
        chk("rr_count", seq_n, 4);
        chk("rr_seq0", seq[0], 0);
        chk("rr_seq1", seq[1], 1);
        chk("rr_seq2", seq[2], 0);
        chk("rr_seq3", seq[3], 1);
        chk("rr_cacks", cacks, 2);
        chk("rr_dacks", dacks, 2);
        chk("rr_overlap", ovl, 0);
        chk("rr_strobe_rules", bad, 0);
        chk("rr_idle", Busy, 0);

        // Latency of WAIT_STATES 3 and 0 instances
        c3_req = 1; c0_req = 1;
        lat3 = 0; lat0 = 0; s3 = 0; s0 = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (!c3_noe) s3++;
            if (!c0_noe) s0++;
            if (c3_ack && lat3 == 0) begin
                lat3 = i;
                c3_req = 0;
            end
            if (c0_ack && lat0 == 0) begin
                lat0 = i;
                c0_req = 0;
            end
        end
        chk("ws3_latency", lat3, 6);
        chk("ws3_strobe", s3, 4);
        chk("ws0_latency", lat0, 3);
        chk("ws0_strobe", s0, 1);

        // CPU alone back-to-back
        CpuReq = 1; CpuWrite = 0; CpuAddr = 16'h0080;
        na = 0; nk = 0; busy5 = 1;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (ALE && na < 2) begin
                ale_c[na] = i;
                na++;
            end
            if (CpuAck && nk < 2) begin
                ack_c[nk] = i;
                nk++;
            end
            if (i == 5) busy5 = Busy;
        end
        CpuReq = 0;
        step();
        chk("b2b_ale_n", na, 2);
        chk("b2b_ale0", ale_c[0], 1);
        chk("b2b_ale1", ale_c[1], 6);
        chk("b2b_ack0", ack_c[0], 4);
        chk("b2b_ack1", ack_c[1], 9);
        chk("b2b_idle_gap", busy5, 0);

        // Reset during second STROBE cycle of a CPU write
        CpuReq = 1; CpuWrite = 1; CpuAddr = 16'h0300; CpuWData = 16'hCAFE;
        step();
        chk("rw_c1_gnt", CpuGnt, 1);
        step();
        step();
        chk("rw_c3_nwe", nWE, 0);
        chk("rw_c3_adout", AdOut, 16'hCAFE);
        nReset = 1'b0;
        #1;
        chk("rw_abort_nwe", nWE, 1);
        chk("rw_abort_nme", nME, 1);
        chk("rw_abort_adoe", AdOe, 0);
        chk("rw_abort_ale", ALE, 0);
        chk("rw_abort_gnt", {CpuGnt, DmaGnt}, 0);
        chk("rw_abort_busy", Busy, 0);
        CpuReq = 0; CpuWrite = 0;
        step();
        step();
        nReset = 1'b1;
        CpuReq = 1; DmaReq = 1; CpuAddr = 16'h0400; DmaAddr = 16'h0500;
        acks = 0;
        step();
        chk("post_rst_gnt", {CpuGnt, DmaGnt}, 2'b10);
        chk("post_rst_adout", AdOut, 16'h0400);
        if (CpuAck || DmaAck) acks++;
        step();
        if (CpuAck || DmaAck) acks++;
        step();
        if (CpuAck || DmaAck) acks++;
        chk("post_rst_no_stale_ack", acks, 0);
        step();
        chk("post_rst_ack", {CpuAck, DmaAck}, 2'b10);
        CpuReq = 0; DmaReq = 0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
